// File: rtl/command_deserializer_pkg.sv
// Shared constants and helpers for the GX FIFO to Command Processor byte deserializer.
package command_deserializer_pkg;

    localparam int WORD_BYTES = 4;   // bytes per GX FIFO word
    localparam int BUF_BYTES  = 8;   // depth of the internal byte queue
    localparam int CNT_W      = 4;   // holds 0..BUF_BYTES

    // Requests above one word are treated as a full-word request.
    function automatic logic [2:0] clamp_req(input logic [2:0] bytes);
        return (bytes > 3'd4) ? 3'd4 : bytes;
    endfunction

endpackage

// File: rtl/command_deserializer_if.sv
// Bundle of the GX FIFO read port and the CP byte-stream port.
// master: the deserializer side; slave: the FIFO/CP environment side.
interface command_deserializer_if;
    import command_deserializer_pkg::*;

    logic                      GXFIFORead;
    logic                      GXFIFOValid;
    logic [WORD_BYTES*8-1:0]   GXFIFOData;
    logic                      CPRead;
    logic                      CPValid;
    logic [2:0]                CPBytes;
    logic [WORD_BYTES*8-1:0]   CPData;

    modport master (
        output GXFIFORead, CPValid, CPData,
        input  GXFIFOValid, GXFIFOData, CPRead, CPBytes
    );

    modport slave (
        input  GXFIFORead, CPValid, CPData,
        output GXFIFOValid, GXFIFOData, CPRead, CPBytes
    );

endinterface

// File: rtl/command_deserializer.sv
// Byte-granular deserializer: buffers up to two 32-bit GX FIFO words and lets the
// Command Processor consume 1..4 bytes per cycle, oldest byte first.
module command_deserializer
    import command_deserializer_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    command_deserializer_if.master bus
);

    localparam logic [BUF_BYTES*8-1:0] ALL_ONES = '1;

    logic [BUF_BYTES*8-1:0]  buf_q;      // byte queue, oldest byte in the top lane
    logic [BUF_BYTES*8-1:0]  buf_next;
    logic [CNT_W-1:0]        cnt_q;      // number of valid bytes in buf_q
    logic [CNT_W-1:0]        cnt_next;
    logic                    rd_q;       // registered GXFIFORead

    logic [2:0]              k_req;
    logic [2:0]              k;
    logic                    acc;
    logic                    cp_valid;
    logic [WORD_BYTES*8-1:0] cp_data;
    logic [CNT_W-1:0]        kept;
    logic [BUF_BYTES*8-1:0]  shifted;
    logic [BUF_BYTES*8-1:0]  keep_mask;
    logic [BUF_BYTES*8-1:0]  ins;

    // Request decode and the CP-facing view of the head of the queue.
    always_comb begin
        k_req    = clamp_req(bus.CPBytes);
        cp_valid = (k_req != 3'd0) && (cnt_q >= {1'b0, k_req});
        k        = (bus.CPRead && cp_valid) ? k_req : 3'd0;
        acc      = rd_q && bus.GXFIFOValid;
        cp_data  = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (CNT_W'(i) < cnt_q)
                cp_data[WORD_BYTES*8-1-8*i -: 8] = buf_q[BUF_BYTES*8-1-8*i -: 8];
        end
    end

    // Shift out consumed bytes, then append an accepted word behind the survivors.
    // rd_q only asserts when at most four bytes remain, so the word always fits.
    always_comb begin
        kept      = cnt_q - CNT_W'(k);
        shifted   = buf_q << {k, 3'b000};
        keep_mask = ~(ALL_ONES >> {kept, 3'b000});
        ins       = '0;
        if (acc)
            ins = {bus.GXFIFOData, {(BUF_BYTES - WORD_BYTES)*8{1'b0}}} >> {kept, 3'b000};
        buf_next  = (shifted & keep_mask) | ins;
        cnt_next  = kept + (acc ? CNT_W'(WORD_BYTES) : CNT_W'(0));
    end

    // Queue, fill level and FIFO read-enable registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q <= '0;
            cnt_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            buf_q <= buf_next;
            cnt_q <= cnt_next;
            rd_q  <= (cnt_next <= CNT_W'(WORD_BYTES));
        end
    end

    assign bus.GXFIFORead = rd_q;
    assign bus.CPValid    = cp_valid;
    assign bus.CPData     = cp_data;

endmodule

// File: tb/tb_command_deserializer.sv
// Directed self-checking bench for command_deserializer.
module tb_command_deserializer;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    command_deserializer_if bus ();

    command_deserializer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at the following falling edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic vld, input logic [31:0] data, input logic rd, input logic [2:0] nb);
        bus.GXFIFOValid = vld;
        bus.GXFIFOData  = data;
        bus.CPRead      = rd;
        bus.CPBytes     = nb;
    endtask

    function automatic logic [31:0] ramp_word(input int i);
        logic [7:0] b;
        b = 8'(i * 4);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 3'd4);

        // ---------------- reset ----------------
        tick();
        tick();
        #1;
        check_val("rst_gxread", bus.GXFIFORead, 1'b0);
        check_val("rst_cpvalid", bus.CPValid, 1'b0);
        check_val("rst_cpdata", bus.CPData, 32'h0);
        resetn = 1'b1;
        #1;
        check_val("rel_gxread_before_edge", bus.GXFIFORead, 1'b0);
        tick();
        #1;
        check_val("rel_gxread_after_edge", bus.GXFIFORead, 1'b1);

        // ---------------- byte-at-a-time drain ----------------
        drive(1'b1, 32'h11223344, 1'b1, 3'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 3'd1);
        #1;
        check_val("b1_data0", bus.CPData, 32'h11223344);
        check_val("b1_vld0", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("b1_data1", bus.CPData, 32'h22334400);
        check_val("b1_vld1", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("b1_data2", bus.CPData, 32'h33440000);
        check_val("b1_vld2", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("b1_data3", bus.CPData, 32'h44000000);
        check_val("b1_vld3", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("b1_empty_vld", bus.CPValid, 1'b0);
        check_val("b1_empty_data", bus.CPData, 32'h0);

        // ---------------- odd-sized reads ----------------
        drive(1'b1, 32'hAABBCCDD, 1'b1, 3'd3);
        tick();
        drive(1'b1, 32'h01020304, 1'b1, 3'd3);
        #1;
        check_val("odd_data0", bus.CPData, 32'hAABBCCDD);
        check_val("odd_vld0", bus.CPValid, 1'b1);
        check_val("odd_gxread0", bus.GXFIFORead, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 3'd3);
        #1;
        check_val("odd_data1", bus.CPData, 32'hDD010203);
        check_val("odd_vld1", bus.CPValid, 1'b1);
        check_val("odd_gxread1", bus.GXFIFORead, 1'b0);
        tick(); #1;
        check_val("odd_left_data", bus.CPData, 32'h03040000);
        check_val("odd_left_vld", bus.CPValid, 1'b0);
        check_val("odd_left_gxread", bus.GXFIFORead, 1'b1);
        // CPRead while CPValid=0 must not consume anything
        tick(); #1;
        check_val("odd_ignored_data", bus.CPData, 32'h03040000);
        // CPBytes=0 consumes nothing
        drive(1'b0, 32'h0, 1'b1, 3'd0);
        #1;
        check_val("odd_zero_vld", bus.CPValid, 1'b0);
        tick(); #1;
        check_val("odd_zero_data", bus.CPData, 32'h03040000);
        drive(1'b0, 32'h0, 1'b1, 3'd2);
        #1;
        check_val("odd_two_vld", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("odd_drained_vld", bus.CPValid, 1'b0);
        check_val("odd_drained_data", bus.CPData, 32'h0);

        // ---------------- backpressure ----------------
        drive(1'b1, 32'hA0A1A2A3, 1'b0, 3'd4);
        tick();
        drive(1'b1, 32'hB0B1B2B3, 1'b0, 3'd4);
        #1;
        check_val("bp_gxread_w1", bus.GXFIFORead, 1'b1);
        tick();
        drive(1'b1, 32'hC0C1C2C3, 1'b0, 3'd4);
        #1;
        check_val("bp_gxread_full", bus.GXFIFORead, 1'b0);
        tick(); #1;
        check_val("bp_gxread_hold", bus.GXFIFORead, 1'b0);
        check_val("bp_head_w0", bus.CPData, 32'hA0A1A2A3);
        drive(1'b1, 32'hC0C1C2C3, 1'b1, 3'd4);
        #1;
        check_val("bp_vld_w0", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("bp_data_w1", bus.CPData, 32'hB0B1B2B3);
        check_val("bp_gxread_resume", bus.GXFIFORead, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 3'd4);
        #1;
        check_val("bp_data_w2", bus.CPData, 32'hC0C1C2C3);
        check_val("bp_vld_w2", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("bp_drained_vld", bus.CPValid, 1'b0);

        // ---------------- full rate ----------------
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, ramp_word(i), 1'b1, 3'd4);
            else        drive(1'b0, 32'h0, 1'b1, 3'd4);
            #1;
            if (i > 0) begin
                check_val($sformatf("fr_data%0d", i - 1), bus.CPData, ramp_word(i - 1));
                check_val($sformatf("fr_vld%0d", i - 1), bus.CPValid, 1'b1);
            end
            check_val($sformatf("fr_gxread%0d", i), bus.GXFIFORead, 1'b1);
            tick();
        end
        #1;
        check_val("fr_drained_vld", bus.CPValid, 1'b0);

        // ---------------- simultaneous consume/accept, CPBytes>4 ----------------
        drive(1'b1, 32'h11121314, 1'b0, 3'd1);
        tick();
        drive(1'b1, 32'h21222324, 1'b1, 3'd1);
        #1;
        check_val("sim_data0", bus.CPData, 32'h11121314);
        tick();
        drive(1'b0, 32'h0, 1'b1, 3'd6);
        #1;
        check_val("sim_data1", bus.CPData, 32'h12131421);
        check_val("sim_gxread", bus.GXFIFORead, 1'b0);
        check_val("sim_b6_vld", bus.CPValid, 1'b1);
        tick(); #1;
        check_val("sim_b6_data", bus.CPData, 32'h22232400);
        check_val("sim_b6_short_vld", bus.CPValid, 1'b0);
        tick(); #1;
        check_val("sim_b6_nocons", bus.CPData, 32'h22232400);
        drive(1'b0, 32'h0, 1'b1, 3'd3);
        #1;
        check_val("sim_b3_vld", bus.CPValid, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 3'd1);
        #1;
        check_val("sim_drained_vld", bus.CPValid, 1'b0);

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 32'h55667788, 1'b0, 3'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 3'd1);
        #1;
        check_val("mr_loaded", bus.CPData, 32'h55667788);
        resetn = 1'b0;
        #1;
        check_val("mr_data", bus.CPData, 32'h0);
        check_val("mr_vld", bus.CPValid, 1'b0);
        check_val("mr_gxread", bus.GXFIFORead, 1'b0);
        tick();
        resetn = 1'b1;
        tick(); #1;
        check_val("mr_rel_gxread", bus.GXFIFORead, 1'b1);
        check_val("mr_rel_vld", bus.CPValid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
